// File: rtl/mac_acc_pkg.sv
// Shared constants for the int8 MAC accumulator: state encoding and default widths.
// Saturating arithmetic is selected by defining MAC_ACC_SATURATE_EN.
package mac_acc_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_ACC_WIDTH = 20;
  localparam int unsigned DEF_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StAcc  = S_ACC,
    StDone = S_DONE
  } state_e;

endpackage

// File: rtl/mac_acc_int8_if.sv
// Job control, product input and result channels of the MAC accumulator.
// The slave modport is the accumulator's view; master is the driver's view.
interface mac_acc_int8_if
  import mac_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
) ();

  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_p;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 busy;
  logic                 ovf;

  modport master (
    output start, len, in_valid, in_p, out_ready,
    input  in_ready, out_valid, out_sum, busy, ovf
  );

  modport slave (
    input  start, len, in_valid, in_p, out_ready,
    output in_ready, out_valid, out_sum, busy, ovf
  );

endinterface

// File: rtl/mac_acc_int8_acc_add_sat.sv
// Combinational accumulator adder: acc + zero-extended product with carry-out.
// With MAC_ACC_SATURATE_EN defined, a carry clamps the sum to all-ones.
module acc_add_sat
  import mac_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]     p_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 carry_o
);

  logic [ACC_WIDTH:0] full;

  assign full    = {1'b0, acc_i} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, p_i};
  assign carry_o = full[ACC_WIDTH];

`ifdef MAC_ACC_SATURATE_EN
  assign sum_o = carry_o ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
  assign sum_o = full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/mac_acc_int8.sv
// Sums a programmed number of unsigned products and returns the total on a valid/ready channel.
// Wraps modulo 2^ACC_WIDTH unless MAC_ACC_SATURATE_EN is defined; ovf flags any carry-out.
module mac_acc_int8
  import mac_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  mac_acc_int8_if.slave bus
);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_carry;

  acc_add_sat #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_add (
    .acc_i  (acc_q),
    .p_i    (bus.in_p),
    .sum_o  (add_sum),
    .carry_o(add_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = bus.len;
          state_d = (bus.len == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        // in_ready is high for the whole state, so in_valid alone is the handshake
        if (bus.in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_sum   = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_acc_int8.sv
// Bench for mac_acc_int8: a 20-bit and a 9-bit accumulator driven with identical stimulus.
// Expected results come from whole-job arithmetic on the product list (MAC_ACC_SATURATE_EN aware).
module tb_mac_acc_int8;

`ifdef MAC_ACC_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start_r;
  logic [7:0] len_r;
  logic       in_valid_r;
  logic [7:0] in_p_r;
  logic       out_ready_r;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [7:0] prods[$];

  mac_acc_int8_if #(.WIDTH(8), .ACC_WIDTH(20), .LEN_WIDTH(8)) if20 ();
  mac_acc_int8_if #(.WIDTH(8), .ACC_WIDTH(9),  .LEN_WIDTH(8)) if9 ();

  assign if20.start     = start_r;
  assign if20.len       = len_r;
  assign if20.in_valid  = in_valid_r;
  assign if20.in_p      = in_p_r;
  assign if20.out_ready = out_ready_r;
  assign if9.start      = start_r;
  assign if9.len        = len_r;
  assign if9.in_valid   = in_valid_r;
  assign if9.in_p       = in_p_r;
  assign if9.out_ready  = out_ready_r;

  mac_acc_int8 #(.WIDTH(8), .ACC_WIDTH(20), .LEN_WIDTH(8)) u_dut20 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if20)
  );

  mac_acc_int8 #(.WIDTH(8), .ACC_WIDTH(9), .LEN_WIDTH(8)) u_dut9 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Result of summing a whole job into an aw-bit register.
  function automatic void model(input int unsigned aw, input longint unsigned total,
                                output logic [31:0] s, output logic o);
    longint unsigned lim;
    lim = 64'd1 << aw;
    o   = (total >= lim);
    if (Sat) s = 32'(o ? lim - 1 : total);
    else     s = 32'(total % lim);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job with the products in prods; start pulses and len changes are thrown in
  // while the block is busy and must have no effect.
  task automatic run_job(input string tag, input int unsigned len, input int unsigned gap,
                         input int unsigned hold, input logic [31:0] e20, input logic e_o20,
                         input logic [31:0] e9, input logic e_o9);
    logic [19:0] s20;
    logic [8:0]  s9;
    bit          stable;
    start_r = 1'b1;
    len_r   = 8'(len);
    step();
    start_r = 1'b0;
    len_r   = 8'($urandom);
    if (len == 0) chk({tag, "_len0_in_ready"}, 32'(if20.in_ready), 32'd0);
    else          chk({tag, "_busy"}, 32'(if20.busy), 32'd1);
    for (int i = 0; i < int'(len); i++) begin
      for (int g = 0; g < int'(gap); g++) begin
        in_valid_r = 1'b0;
        in_p_r     = 8'($urandom);
        start_r    = 1'($urandom_range(0, 1));
        len_r      = 8'($urandom);
        step();
      end
      start_r    = 1'($urandom_range(0, 1));
      in_valid_r = 1'b1;
      in_p_r     = prods[i];
      if (i == int'(len) - 1) begin
        chk({tag, "_in_ready_acc"}, 32'(if20.in_ready), 32'd1);
        chk({tag, "_no_early_valid"}, 32'(if20.out_valid), 32'd0);
      end
      step();
    end
    in_valid_r = 1'b0;
    start_r    = 1'b0;
    chk({tag, "_out_valid_latency"}, 32'(if20.out_valid), 32'd1);
    chk({tag, "_in_ready_done"}, 32'(if20.in_ready), 32'd0);
    s20    = if20.out_sum;
    s9     = if9.out_sum;
    stable = 1'b1;
    out_ready_r = 1'b0;
    for (int h = 0; h < int'(hold); h++) begin
      start_r = 1'($urandom_range(0, 1));
      len_r   = 8'($urandom);
      step();
      if (if20.out_valid !== 1'b1 || if20.out_sum !== s20 || if9.out_sum !== s9) stable = 1'b0;
    end
    start_r = 1'b0;
    chk({tag, "_sum20"}, 32'(if20.out_sum), e20);
    chk({tag, "_ovf20"}, 32'(if20.ovf), 32'(e_o20));
    chk({tag, "_sum9"}, 32'(if9.out_sum), e9);
    chk({tag, "_ovf9"}, 32'(if9.ovf), 32'(e_o9));
    if (hold > 0) chk({tag, "_held_stable"}, 32'(stable), 32'd1);
    out_ready_r = 1'b1;
    step();
    out_ready_r = 1'b0;
    chk({tag, "_idle_after"}, 32'({if20.busy, if20.out_valid, if9.busy}), 32'd0);
  endtask

  typedef struct {
    int unsigned     len;
    int unsigned     gap;
    int unsigned     hold;
    logic [3:0][7:0] p;
    logic [19:0]     s20;
    logic            o20;
    logic [8:0]      s9;
    logic            o9;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0]     e20, e9;
    logic            o20, o9;
    longint unsigned total;
    int unsigned     len;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{len: 4, gap: 0, hold: 0, p: {8'd9, 8'd7, 8'd5, 8'd3},
                s20: 20'd24, o20: 1'b0, s9: 9'd24, o9: 1'b0};
    vecs[1] = '{len: 3, gap: 2, hold: 5, p: {8'd0, 8'd255, 8'd255, 8'd255},
                s20: 20'd765, o20: 1'b0, s9: Sat ? 9'd511 : 9'd253, o9: 1'b1};
    vecs[2] = '{len: 0, gap: 0, hold: 2, p: '0,
                s20: 20'd0, o20: 1'b0, s9: 9'd0, o9: 1'b0};
    vecs[3] = '{len: 3, gap: 1, hold: 2, p: {8'd0, 8'd200, 8'd200, 8'd200},
                s20: 20'd600, o20: 1'b0, s9: Sat ? 9'd511 : 9'd88, o9: 1'b1};

    rst_n       = 1'b0;
    start_r     = 1'b0;
    len_r       = '0;
    in_valid_r  = 1'b0;
    in_p_r      = '0;
    out_ready_r = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs20",
        32'({if20.in_ready, if20.out_valid, if20.busy, if20.ovf, if20.out_sum}), 32'd0);
    chk("reset_outputs9",
        32'({if9.in_ready, if9.out_valid, if9.busy, if9.ovf, if9.out_sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      prods.delete();
      for (int i = 0; i < int'(vecs[v].len); i++) prods.push_back(vecs[v].p[i]);
      run_job($sformatf("vec%0d", v), vecs[v].len, vecs[v].gap, vecs[v].hold,
              32'(vecs[v].s20), vecs[v].o20, 32'(vecs[v].s9), vecs[v].o9);
    end

    // Asynchronous reset after 2 of 4 products: partial sum discarded, no result.
    start_r = 1'b1;
    len_r   = 8'd4;
    step();
    start_r    = 1'b0;
    in_valid_r = 1'b1;
    in_p_r     = 8'd3;
    step();
    in_p_r = 8'd5;
    step();
    in_valid_r = 1'b0;
    chk("pre_reset_partial", 32'(if20.out_sum), 32'd8);
    rst_n = 1'b0;
    #1;
    chk("async_reset20",
        32'({if20.in_ready, if20.out_valid, if20.busy, if20.ovf, if20.out_sum}), 32'd0);
    chk("async_reset9", 32'({if9.busy, if9.out_sum}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", 32'({if20.busy, if20.out_valid}), 32'd0);
    prods.delete();
    for (int i = 0; i < 4; i++) prods.push_back(vecs[0].p[i]);
    run_job("clean_after_reset", 4, 0, 1, 32'd24, 1'b0, 32'd24, 1'b0);

    for (int j = 0; j < 40; j++) begin
      len   = $urandom_range(0, 20);
      total = 0;
      prods.delete();
      for (int i = 0; i < int'(len); i++) begin
        prods.push_back(8'($urandom));
        total += longint'(prods[i]);
      end
      model(20, total, e20, o20);
      model(9, total, e9, o9);
      run_job($sformatf("rnd%0d", j), len, $urandom_range(0, 2), $urandom_range(0, 3),
              e20, o20, e9, o9);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_acc_int8.md
Name: mac_acc_int8

Overview:
- Sequential accumulator that sits directly downstream of the 8-bit integer multiplier.
- Consumes a stream of WIDTH-bit products and sums a programmed number of them.
- Returns the sum on a valid/ready output channel.
- Together with the multiplier it forms an int8 dot-product/MAC benchmark for bit-serial PIM synthesis.

Parameters:
WIDTH, 8, width of each incoming product (low bits of the multiplier output, unsigned)
ACC_WIDTH, 20, accumulator/result width; must be >= WIDTH
LEN_WIDTH, 8, width of the programmed product count

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new accumulation; sampled only in IDLE
len  input  LEN_WIDTH  number of products to accumulate, sampled with start
in_valid  input  1  product available on in_p
in_ready  output  1  block accepts a product this cycle
in_p  input  WIDTH  product from multiplier, unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  ACC_WIDTH  accumulated result
busy  output  1  state != IDLE
ovf  output  1  sticky overflow flag for current job

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state IDLE; acc, cnt, out_sum = 0; in_ready, out_valid, busy, ovf = 0. Reset asserted mid-job discards the partial sum with no output.
- States: IDLE, ACC, DONE. Encoding is 2-bit.
- IDLE:
  - in_ready=0, out_valid=0.
  - start & len!=0 -> ACC next cycle; acc<=0, cnt<=len, ovf<=0.
  - start & len==0 -> DONE next cycle; out_sum=0, ovf=0.
- ACC:
  - in_ready=1 (registered or combinational from state; must be 1 every ACC cycle).
  - Each in_valid&in_ready handshake: acc <= acc + zero_ext(in_p), cnt <= cnt-1.
  - Handshake with cnt==1 -> DONE next cycle; out_sum = final acc including that product.
  - Latency: out_valid rises exactly 1 cycle after the last input handshake.
  - in_valid low stalls with no change to acc or cnt.
- DONE:
  - out_valid=1; out_sum and ovf held stable; in_ready=0.
  - out_valid&out_ready -> IDLE next cycle; out_valid drops.
  - A new job needs a start in a later cycle; no start/result-handshake overlap.
- start outside IDLE is ignored; len is not re-sampled.
- Arithmetic: unsigned; sum is modulo 2^ACC_WIDTH by default.
- ovf is set when any addition carries out of ACC_WIDTH bits. It is cleared on accepted start and held through DONE.
- busy = (state != IDLE).

Optional Feature:
- Macro: MAC_ACC_SATURATE_EN.
- Defined: an addition that would exceed 2^ACC_WIDTH-1 clamps acc to all-ones and sets ovf. acc stays clamped for the rest of the job.
- Undefined: acc wraps modulo 2^ACC_WIDTH; ovf still reports the carry-out.
- Ports are identical in both builds.

Decomposition:
- Shared package mac_acc_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_ACC=2'd1, S_DONE=2'd2;
  - default width constants (WIDTH, ACC_WIDTH, LEN_WIDTH).
- One sub-module, acc_add_sat: combinational ACC_WIDTH adder of acc + zero-extended product, giving sum and carry.
  - The clamp mux is compiled in under MAC_ACC_SATURATE_EN.
  - The top holds the FSM, counter and registers.

Test Plan:
- Reset mid-ACC (after 2 of 4 products) -> all outputs 0 asynchronously, state IDLE; next job starts clean.
- start len=4, products 3,5,7,9 with continuous in_valid -> out_valid exactly 1 cycle after 4th handshake, out_sum=24, ovf=0.
- start len=3, products 255,255,255 with in_valid gaps of 2 cycles and out_ready held low 5 cycles -> out_sum=765 stable until handshake, then IDLE.
- start len=0 -> DONE next cycle with out_sum=0; in_ready never asserts.
- ACC_WIDTH=9, len=3, products 200,200,200:
  - without macro -> out_sum=88, ovf=1;
  - with MAC_ACC_SATURATE_EN -> out_sum=511, ovf=1.
- start pulsed during ACC and DONE -> ignored; len change during ACC does not alter the product count.
